// File: rtl/zxw_dm_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Owner encoding, FSM states and the I/O window helper.
package zxw_dm_pkg;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 14;

    localparam logic [ADDR_W-1:0] IO_LO_DEF = 14'h3F00;
    localparam logic [ADDR_W-1:0] IO_HI_DEF = 14'h3FFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // Both bounds are exclusive: the edge addresses stay RAM.
    function automatic logic in_io(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] lo,
        input logic [ADDR_W-1:0] hi
    );
        return (a > lo) && (a < hi);
    endfunction

endpackage

// File: rtl/zxw_rr_arb2.sv
// Two-input round-robin picker.
// Combinational; the parent keeps the pointer.
module zxw_rr_arb2
    import zxw_dm_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    output owner_e     winner,
    output logic       any
);

    // Lone requester wins; on contention the port not served last wins.
    always_comb begin
        any    = |req;
        winner = OWN_CPU;
        unique case (req)
            2'b01:   winner = OWN_CPU;
            2'b10:   winner = OWN_DBG;
            2'b11:   winner = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
            default: winner = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/zxw_dm_arbiter.sv
// Data-memory sequencer shared by CPU and debug port.
// Round-robin grant, fixed wait states, I/O window decode.
module zxw_dm_arbiter
    import zxw_dm_pkg::*;
#(
    parameter int unsigned       WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_LO       = IO_LO_DEF,
    parameter logic [ADDR_W-1:0] IO_HI       = IO_HI_DEF
) (
    input  logic              Clock_pin,
    input  logic              Resetn_pin,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              cpu_gnt,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic [4:0]        SW_pin,
    output logic [7:0]        Display_pin
);

    localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

    state_e            state_q;
    state_e            state_d;
    owner_e            rr_ptr;
    owner_e            last_owner;
    owner_e            owner_q;
    owner_e            winner;
    logic              any;
    logic              we_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [7:0]        disp_q;
    logic              mem_we_q;
    logic              cpu_gnt_q;
    logic              dbg_gnt_q;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              io_sel;

    // rr_ptr names the port that wins the next tie.
    assign last_owner = (rr_ptr == OWN_CPU) ? OWN_DBG : OWN_CPU;

    zxw_rr_arb2 u_arb (
        .req        ({dbg_req, cpu_req}),
        .last_owner (last_owner),
        .winner     (winner),
        .any        (any)
    );

    assign sel_we    = (winner == OWN_DBG) ? dbg_we    : cpu_we;
    assign sel_addr  = (winner == OWN_DBG) ? dbg_addr  : cpu_addr;
    assign sel_wdata = (winner == OWN_DBG) ? dbg_wdata : cpu_wdata;
    assign io_sel    = in_io(sel_addr, IO_LO, IO_HI);

    // State register.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Next state: I/O finishes at once, RAM goes through ACCESS.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any) state_d = io_sel ? DONE : ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning access, run wait states, raise gnt into DONE.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            rr_ptr    <= OWN_CPU;
            owner_q   <= OWN_CPU;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            disp_q    <= '0;
            mem_we_q  <= 1'b0;
            cpu_gnt_q <= 1'b0;
            dbg_gnt_q <= 1'b0;
        end else begin
            mem_we_q  <= 1'b0;
            cpu_gnt_q <= 1'b0;
            dbg_gnt_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any) begin
                        owner_q <= winner;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        if (io_sel) begin
                            if (sel_we) disp_q  <= sel_wdata[7:0];
                            else        rdata_q <= {{(DATA_W-5){1'b0}}, SW_pin};
                            cpu_gnt_q <= (winner == OWN_CPU);
                            dbg_gnt_q <= (winner == OWN_DBG);
                        end else begin
                            cnt_q    <= WS_INIT;
                            mem_we_q <= sel_we;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!we_q) rdata_q <= mem_dout;
                        cpu_gnt_q <= (owner_q == OWN_CPU);
                        dbg_gnt_q <= (owner_q == OWN_DBG);
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    rr_ptr <= (owner_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
                end
                default: ;
            endcase
        end
    end

    assign cpu_gnt     = cpu_gnt_q;
    assign dbg_gnt     = dbg_gnt_q;
    assign rdata       = rdata_q;
    assign cpu_stall   = cpu_req & ~cpu_gnt_q;
    assign busy        = (state_q != IDLE);
    assign mem_addr    = addr_q;
    assign mem_din     = wdata_q;
    assign mem_we      = mem_we_q;
    assign Display_pin = disp_q;

endmodule

// File: tb/tb_zxw_dm_arbiter.sv
// Directed bench for zxw_dm_arbiter.
// Main DUT uses 2 wait states; a second copy uses 0.
module tb_zxw_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [13:0] cpu_wdata = '0;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [13:0] dbg_addr = '0;
    logic [13:0] dbg_wdata = '0;
    logic [4:0]  sw = '0;

    logic        cpu_gnt, dbg_gnt, cpu_stall, busy, mem_we;
    logic [13:0] rdata, mem_addr, mem_din, mem_dout;
    logic [7:0]  disp;

    logic        cpu_req0 = 1'b0;
    logic        zero1 = 1'b0;
    logic [13:0] zero14 = '0;
    logic [13:0] dout0 = 14'h0ABC;
    logic        cpu_gnt0, dbg_gnt0, cpu_stall0, busy0, mem_we0;
    logic [13:0] rdata0, mem_addr0, mem_din0;
    logic [7:0]  disp0;

    logic [13:0] ram [0:16383];

    int cyc = 0;
    int t0 = 0;
    int we_cnt = 0;
    int we_cyc = 0;
    logic [13:0] we_addr = '0;
    int n_chk = 0;
    int n_pass = 0;

    zxw_dm_arbiter #(.WAIT_STATES(2)) dut (
        .Clock_pin   (clk),
        .Resetn_pin  (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .cpu_gnt     (cpu_gnt),
        .dbg_gnt     (dbg_gnt),
        .rdata       (rdata),
        .cpu_stall   (cpu_stall),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout),
        .SW_pin      (sw),
        .Display_pin (disp)
    );

    zxw_dm_arbiter #(.WAIT_STATES(0)) dut0 (
        .Clock_pin   (clk),
        .Resetn_pin  (rst_n),
        .cpu_req     (cpu_req0),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .dbg_req     (zero1),
        .dbg_we      (zero1),
        .dbg_addr    (zero14),
        .dbg_wdata   (zero14),
        .cpu_gnt     (cpu_gnt0),
        .dbg_gnt     (dbg_gnt0),
        .rdata       (rdata0),
        .cpu_stall   (cpu_stall0),
        .busy        (busy0),
        .mem_addr    (mem_addr0),
        .mem_din     (mem_din0),
        .mem_we      (mem_we0),
        .mem_dout    (dout0),
        .SW_pin      (sw),
        .Display_pin (disp0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_dout = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt  = we_cnt + 1;
            we_cyc  = cyc;
            we_addr = mem_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One access on the main DUT; returns gnt latency and rdata.
    task automatic xact(input bit d, input bit we, input logic [13:0] a,
                        input logic [13:0] wd, output int lat,
                        output logic [13:0] rd, output int stall_bad);
        logic g;
        @(posedge clk); #1;
        we_cnt = 0;
        stall_bad = 0;
        if (d) begin
            dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        end
        t0 = cyc;
        lat = -1;
        rd = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            g = d ? dbg_gnt : cpu_gnt;
            if (cpu_stall !== (!d && !g)) stall_bad++;
            if (g) begin
                lat = cyc - t0;
                rd = rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    // One CPU access on the zero-wait DUT.
    task automatic xact0(input logic [13:0] a, output int lat,
                         output logic [13:0] rd);
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = a; cpu_req0 = 1'b1;
        t0 = cyc;
        lat = -1;
        rd = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (cpu_gnt0) begin
                lat = cyc - t0;
                rd = rdata0;
                break;
            end
        end
        cpu_req0 = 1'b0;
    endtask

    // Both ports hold loads; record who is granted, in order.
    task automatic arb_seq(input int n, output logic [3:0] order,
                           output int got, output logic [13:0] rd0,
                           output logic [13:0] rd1);
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 14'h0010; cpu_req = 1'b1;
        dbg_we = 1'b0; dbg_addr = 14'h0011; dbg_req = 1'b1;
        order = '0;
        got = 0;
        rd0 = '0;
        rd1 = '0;
        for (int i = 0; i < 12 * n; i++) begin
            @(negedge clk);
            if (cpu_gnt || dbg_gnt) begin
                order[got] = dbg_gnt;
                if (got == 0) rd0 = rdata;
                if (got == 1) rd1 = rdata;
                got++;
                if (got == n) break;
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        cpu_req = 1'b0; dbg_req = 1'b0; cpu_req0 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        int sb;
        int got;
        int gcnt;
        logic [13:0] rd, rd1;
        logic [3:0] order;

        ram[14'h0010] = 14'h1234;
        ram[14'h0011] = 14'h0BAD;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {cpu_gnt, dbg_gnt}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem", {mem_we, mem_addr, mem_din}, 0);
        chk("rst_disp", disp, 0);
        chk("rst_stall", cpu_stall, 0);
        rst_n = 1'b1;

        xact(0, 0, 14'h0010, 14'h0, lat, rd, sb);
        chk("ld_lat", lat, 4);
        chk("ld_data", rd, 14'h1234);
        chk("ld_stall", sb, 0);
        chk("ld_no_we", we_cnt, 0);

        do_reset();
        arb_seq(4, order, got, rd, rd1);
        chk("arb_cnt", got, 4);
        chk("arb_order", order, 4'b1010);
        chk("arb_cpu_rd", rd, 14'h1234);
        chk("arb_dbg_rd", rd1, 14'h0BAD);

        xact(0, 1, 14'h3F10, 14'h00A5, lat, rd, sb);
        chk("io_st_lat", lat, 1);
        chk("io_st_disp", disp, 8'hA5);
        chk("io_st_no_we", we_cnt, 0);

        sw = 5'b10110;
        xact(0, 0, 14'h3F10, 14'h0, lat, rd, sb);
        chk("io_ld_lat", lat, 1);
        chk("io_ld_data", rd, 14'h0016);

        xact(1, 1, 14'h3FFF, 14'h0777, lat, rd, sb);
        chk("hi_st_lat", lat, 4);
        chk("hi_st_we", we_cnt, 1);
        chk("hi_st_addr", we_addr, 14'h3FFF);
        chk("hi_st_we_cyc", we_cyc - t0, 1);
        chk("hi_st_disp", disp, 8'hA5);
        chk("dbg_stall", sb, 0);

        xact(0, 1, 14'h3F00, 14'h0123, lat, rd, sb);
        chk("lo_st_lat", lat, 4);
        chk("lo_st_we", we_cnt, 1);
        chk("lo_st_addr", we_addr, 14'h3F00);

        sw = 5'b00001;
        xact(0, 0, 14'h3F01, 14'h0, lat, rd, sb);
        chk("io_edge_lat", lat, 1);
        chk("io_edge_data", rd, 14'h0001);

        xact(0, 0, 14'h3FFF, 14'h0, lat, rd, sb);
        chk("hi_ld_lat", lat, 4);
        chk("hi_ld_data", rd, 14'h0777);

        xact(0, 1, 14'h0030, 14'h0055, lat, rd, sb);
        chk("st_keeps_rd", rd, 14'h0777);

        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = 14'h0020;
        cpu_wdata = 14'h0155; cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_we", mem_we, 1);
        chk("pre_rst_busy", busy, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out", {cpu_gnt, dbg_gnt, mem_we, cpu_stall}, 0);
        chk("mid_rst_bus", {mem_addr, mem_din}, 0);
        chk("mid_rst_rd", rdata, 0);
        chk("mid_rst_disp", disp, 0);
        @(negedge clk);
        rst_n = 1'b1;
        we_cnt = 0;
        gcnt = 0;
        repeat (8) begin
            @(negedge clk);
            gcnt += int'(cpu_gnt) + int'(dbg_gnt);
        end
        chk("post_rst_gnt", gcnt, 0);
        chk("post_rst_we", we_cnt, 0);

        arb_seq(1, order, got, rd, rd1);
        chk("post_rst_cnt", got, 1);
        chk("post_rst_cpu", order[0], 0);
        chk("post_rst_rd", rd, 14'h1234);

        xact0(14'h0010, lat, rd);
        chk("ws0_ram_lat", lat, 2);
        chk("ws0_ram_rd", rd, 14'h0ABC);
        sw = 5'b01010;
        xact0(14'h3F20, lat, rd);
        chk("ws0_io_lat", lat, 1);
        chk("ws0_io_rd", rd, 14'h000A);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/zxw_dm_arbiter.md
# zxw_dm_arbiter

Sequencing controller for the single-port 14-bit data memory, shared between the CPU load/store stage and a debug/loader port. Arbitrates round-robin, drives the memory with a fixed wait-state count, decodes the memory-mapped I/O window (switches in, display out), and produces the CPU stall. Sits between the pipeline's MC2/MC3 memory stages, the data RAM, and the board pins.

## Interface
- WAIT_STATES, 2: extra memory cycles per RAM access (0–7).
- IO_LO, 14'h3F00: I/O window lower bound, exclusive.
- IO_HI, 14'h3FFF: I/O window upper bound, exclusive.

- Clock_pin  in  1  sole clock; all state updates on the rising edge.
- Resetn_pin  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  14  CPU effective address.
- cpu_wdata  in  14  CPU store data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/14/14  debug port, same semantics.
- cpu_gnt  out  1  one-cycle completion pulse to the CPU.
- dbg_gnt  out  1  one-cycle completion pulse to the debug port.
- rdata  out  14  load data; valid only in the gnt cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- busy  out  1  state != IDLE.
- mem_addr  out  14  RAM address.
- mem_din  out  14  RAM write data.
- mem_we  out  1  RAM write strobe.
- mem_dout  in  14  RAM read data.
- SW_pin  in  5  switch inputs.
- Display_pin  out  8  display register.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: when any req is high, select the winner (round-robin), latch its we/addr/wdata and owner.
  - I/O address (IO_LO < addr < IO_HI): go to DONE.
    - Load: rdata = {9'b0, SW_pin} sampled this cycle.
    - Store: Display_pin <= wdata[7:0].
  - Otherwise: go to ACCESS and load the wait counter with WAIT_STATES.
- ACCESS: mem_addr/mem_din hold the latched values throughout.
  - mem_we is high in the first ACCESS cycle only, for stores.
  - Counter decrements each cycle. When it reaches 0, capture mem_dout into rdata (loads) and go to DONE.
- DONE: assert the owner's gnt for exactly one cycle, update the round-robin pointer to the other port, return to IDLE.
- Arbitration:
  - Both requesting: the port not served last wins.
  - After reset, CPU wins first.
  - A single requester always wins.
- Addresses 14'h3F00 and 14'h3FFF are RAM, not I/O.
- A request withdrawn before gnt is a protocol violation. The latched access still completes and gnt still pulses.
- Stores to RAM do not change rdata.
- Only one access is in flight at a time. A requester may re-request in the cycle after its gnt.

## Timing
- Reset (asynchronous, any state):
  - Returns to IDLE; pointer = CPU.
  - cpu_gnt = dbg_gnt = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_din = 0, Display_pin = 0, busy = 0.
  - An access in progress is abandoned: no gnt, and no further mem_we.
- Request first seen high in IDLE at cycle N:
  - RAM access: gnt at cycle N+WAIT_STATES+2.
  - I/O access: gnt at cycle N+1.
- mem_we, when asserted, occurs at cycle N+1.
- The next request can be accepted in IDLE at gnt cycle + 1.
- cpu_stall is combinational from cpu_req and the registered cpu_gnt.

## Structure
- Package zxw_dm_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - DATA_W = 14, ADDR_W = 14;
  - default IO_LO / IO_HI constants;
  - owner encoding CPU = 0, DBG = 1.
- Sub-module zxw_rr_arb2: two-request round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: winner, any.
  - Purely combinational; the pointer register stays in the parent.
- Expected size: approximately 200 lines.

## Test plan
- CPU load from 14'h0010 with the RAM model holding 14'h1234, WAIT_STATES = 2, req at cycle 5 → cpu_gnt at cycle 9, rdata = 14'h1234, cpu_stall high on cycles 5–8.
- CPU and debug both request at the same cycle after reset → CPU granted first, debug second. Repeat with both held → grants alternate CPU, DBG, CPU, DBG.
- Store of 14'h00A5 to 14'h3F10 → gnt one cycle after req, Display_pin = 8'hA5, mem_we never asserted. Load from 14'h3F10 with SW_pin = 5'b10110 → rdata = 14'h0016.
- Store to 14'h3FFF with data 14'h0777 → RAM write occurs (mem_we one cycle, mem_addr = 14'h3FFF), Display_pin unchanged. Subsequent load from 14'h3FFF returns 14'h0777.
- Resetn_pin pulsed low during ACCESS of a store → no gnt, mem_we low, state IDLE, all outputs 0. The next CPU request completes normally with CPU priority.
- WAIT_STATES = 0 build → RAM gnt at N+2, I/O gnt at N+1.
